// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared baud-select encodings, limits and divisor helper for
//               the UART timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4,
        BAUD_CUSTOM = 3'd5
    } baud_sel_e;

    localparam int MIN_DIV   = 31;
    localparam int OS_FACTOR = 16;

    // Bit period in clocks, rounded to nearest, minus one.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tick_counter
// Description : Generic wrap counter: counts while enabled, wraps at limit,
//               synchronous clear has priority.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tick_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] r_cnt;

    // Terminal count is reported even when clr forces a restart in the same cycle.
    assign wrap = en & (r_cnt == limit);
    assign cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= wrap ? '0 : r_cnt + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Baud-rate timing generator: mid-bit sample, bit-end, 16x
//               oversample ticks and frame bit counting with auto-stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int CNT_W      = 16,
    parameter int FRAME_BITS = 10,
    parameter int AUTO_STOP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bps_start,
    input  logic [2:0]       baud_sel,
    input  logic [CNT_W-1:0] div_custom,
    output logic             clk_bps,
    output logic             bit_end,
    output logic             os_tick,
    output logic [3:0]       bit_idx,
    output logic             frame_done,
    output logic             busy
);

    localparam int c_OS_SHIFT = $clog2(OS_FACTOR);

    function automatic logic [CNT_W-1:0] os_div_of(input logic [CNT_W-1:0] div);
        logic [CNT_W:0] p1;
        p1 = {1'b0, div} + (CNT_W+1)'(1);
        p1 = (p1 >> c_OS_SHIFT) - (CNT_W+1)'(1);
        return p1[CNT_W-1:0];
    endfunction

    localparam logic [CNT_W-1:0] c_DIV_9600   = CNT_W'(baud_div(CLK_FREQ, 9600));
    localparam logic [CNT_W-1:0] c_DIV_19200  = CNT_W'(baud_div(CLK_FREQ, 19200));
    localparam logic [CNT_W-1:0] c_DIV_38400  = CNT_W'(baud_div(CLK_FREQ, 38400));
    localparam logic [CNT_W-1:0] c_DIV_57600  = CNT_W'(baud_div(CLK_FREQ, 57600));
    localparam logic [CNT_W-1:0] c_DIV_115200 = CNT_W'(baud_div(CLK_FREQ, 115200));
    localparam logic [CNT_W-1:0] c_MIN_DIV    = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] c_HALF_9600  = c_DIV_9600 >> 1;
    localparam logic [CNT_W-1:0] c_OS_9600    = os_div_of(c_DIV_9600);
    localparam logic [3:0]       c_LAST_BIT   = 4'(FRAME_BITS - 1);

    logic [CNT_W-1:0] w_div_sel;
    logic             w_running;
    logic             w_latch;
    logic             w_bit_wrap;
    logic             w_os_wrap;
    logic             w_frame_wrap;
    logic             w_cnt_clr;
    logic             w_os_clr;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_os_cnt_unused;

    logic [CNT_W-1:0] r_div_q;
    logic [CNT_W-1:0] r_half_q;
    logic [CNT_W-1:0] r_os_div_q;
    logic [3:0]       r_bit_idx;
    logic             r_halted;
    logic             r_clk_bps;
    logic             r_bit_end;
    logic             r_os_tick;
    logic             r_frame_done;
    logic             r_busy;

    always_comb begin
        w_div_sel = c_DIV_9600;
        case (baud_sel_e'(baud_sel))
            BAUD_19200:  w_div_sel = c_DIV_19200;
            BAUD_38400:  w_div_sel = c_DIV_38400;
            BAUD_57600:  w_div_sel = c_DIV_57600;
            BAUD_115200: w_div_sel = c_DIV_115200;
            BAUD_CUSTOM: w_div_sel = (div_custom < c_MIN_DIV) ? c_MIN_DIV : div_custom;
            default:     w_div_sel = c_DIV_9600;
        endcase
    end

    assign w_running    = bps_start & ~r_halted;
    assign w_cnt_clr    = ~w_running;
    // Oversample phase restarts with every bit so ticks stay bit-aligned.
    assign w_os_clr     = ~w_running | w_bit_wrap;
    assign w_latch      = ~w_running | w_bit_wrap;
    assign w_frame_wrap = w_bit_wrap & (r_bit_idx == c_LAST_BIT);

    uart_tick_counter #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_running),
        .clr   (w_cnt_clr),
        .limit (r_div_q),
        .cnt   (w_cnt),
        .wrap  (w_bit_wrap)
    );

    uart_tick_counter #(.W(CNT_W)) u_os_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_running),
        .clr   (w_os_clr),
        .limit (r_os_div_q),
        .cnt   (w_os_cnt_unused),
        .wrap  (w_os_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q      <= c_DIV_9600;
            r_half_q     <= c_HALF_9600;
            r_os_div_q   <= c_OS_9600;
            r_bit_idx    <= 4'd0;
            r_halted     <= 1'b0;
            r_clk_bps    <= 1'b0;
            r_bit_end    <= 1'b0;
            r_os_tick    <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Divisor only changes between bits, never inside one.
            if (w_latch) begin
                r_div_q    <= w_div_sel;
                r_half_q   <= w_div_sel >> 1;
                r_os_div_q <= os_div_of(w_div_sel);
            end
            r_clk_bps    <= w_running & (w_cnt == r_half_q);
            r_bit_end    <= w_bit_wrap;
            r_os_tick    <= w_os_wrap;
            r_frame_done <= w_frame_wrap;
            r_busy       <= w_running;

            if (!w_running) begin
                r_bit_idx <= 4'd0;
            end else if (w_bit_wrap) begin
                r_bit_idx <= w_frame_wrap ? 4'd0 : r_bit_idx + 4'd1;
            end

            if (!bps_start) begin
                r_halted <= 1'b0;
            end else if (w_frame_wrap && (AUTO_STOP != 0)) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign clk_bps    = r_clk_bps;
    assign bit_end    = r_bit_end;
    assign os_tick    = r_os_tick;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign bit_idx    = r_bit_idx;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_baud_gen
// Description : Self-checking bench for uart_baud_gen: pulse timing scoreboard
//               plus baud table and multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_baud_gen;

    localparam int FRAME = 10;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] cust;
        int          div;
        int          half;
        int          osd;
    } vec_t;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        bps_start  = 1'b0;
    logic [2:0]  baud_sel   = 3'd0;
    logic [15:0] div_custom = 16'd0;
    logic        clk_bps, bit_end, os_tick, frame_done, busy;
    logic [3:0]  bit_idx;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int t0       = 0;

    // Expected stamps per pulse: 0=clk_bps 1=bit_end 2=os_tick 3=frame_done
    int    q_exp [4][$];
    string pname [4] = '{"clk_bps", "bit_end", "os_tick", "frame_done"};

    uart_baud_gen #(
        .CLK_FREQ   (50000000),
        .CNT_W      (16),
        .FRAME_BITS (FRAME),
        .AUTO_STOP  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bps_start  (bps_start),
        .baud_sel   (baud_sel),
        .div_custom (div_custom),
        .clk_bps    (clk_bps),
        .bit_end    (bit_end),
        .os_tick    (os_tick),
        .bit_idx    (bit_idx),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        logic [3:0] p;
        int         e;
        p = {frame_done, os_tick, bit_end, clk_bps};
        for (int k = 0; k < 4; k++) begin
            if (p[k]) begin
                checks++;
                if (q_exp[k].size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected pulse at stamp %0d, none required", pname[k], edge_cnt);
                end else begin
                    e = q_exp[k].pop_front();
                    if (e != edge_cnt) begin
                        errors++;
                        $display("FAIL %s pulse at stamp %0d, required %0d", pname[k], edge_cnt, e);
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout at stamp %0d", edge_cnt);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Edge E after the start edge is observed at stamp t0+1+E.
    task automatic expect_bits(input int base, input int div, input int half, input int osd,
                               input int nbits, input int idx0, input int cutoff);
        for (int b = 0; b < nbits; b++) begin
            int bb;
            bb = base + b * (div + 1);
            if (bb + half <= cutoff) q_exp[0].push_back(t0 + 1 + bb + half);
            for (int c = osd; c <= div; c += osd + 1)
                if (bb + c <= cutoff) q_exp[2].push_back(t0 + 1 + bb + c);
            if (bb + div <= cutoff) begin
                q_exp[1].push_back(t0 + 1 + bb + div);
                if (((idx0 + b) % FRAME) == FRAME - 1) q_exp[3].push_back(t0 + 1 + bb + div);
            end
        end
    endtask

    task automatic wait_stamp(input int s);
        while (edge_cnt < s) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bps_start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_run();
        @(negedge clk);
        bps_start = 1'b1;
        t0 = edge_cnt;
    endtask

    task automatic flush(input string name);
        checks++;
        if (q_exp[0].size() + q_exp[1].size() + q_exp[2].size() + q_exp[3].size() != 0) begin
            errors++;
            $display("FAIL %s missing pulses bps %0d end %0d os %0d fd %0d, required 0", name,
                     q_exp[0].size(), q_exp[1].size(), q_exp[2].size(), q_exp[3].size());
        end
        for (int k = 0; k < 4; k++) q_exp[k].delete();
    endtask

    initial begin
        vec_t vt [7];
        vt[0] = '{3'd0, 16'd0,   5207, 2603, 324};
        vt[1] = '{3'd1, 16'd0,   2603, 1301, 161};
        vt[2] = '{3'd2, 16'd0,   1301,  650,  80};
        vt[3] = '{3'd3, 16'd0,    867,  433,  53};
        vt[4] = '{3'd4, 16'd0,    433,  216,  26};
        vt[5] = '{3'd5, 16'd10,    31,   15,   1};
        vt[6] = '{3'd7, 16'd0,   5207, 2603, 324};

        repeat (3) @(negedge clk);
        chk("reset_clk_bps", clk_bps, 0);
        chk("reset_bit_end", bit_end, 0);
        chk("reset_os_tick", os_tick, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_bit_idx", bit_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            baud_sel   = vt[i].sel;
            div_custom = vt[i].cust;
            idle(2);
            start_run();
            expect_bits(0, vt[i].div, vt[i].half, vt[i].osd, 2, 0, 2 * (vt[i].div + 1) - 1);
            wait_stamp(t0 + 1 + vt[i].half);
            chk("table_busy_run", busy, 1);
            wait_stamp(t0 + 1 + 2 * (vt[i].div + 1) - 1);
            chk("table_bit_idx_run", bit_idx, 2);
            bps_start = 1'b0;
            @(negedge clk);
            chk("table_busy_stop", busy, 0);
            chk("table_bit_idx_stop", bit_idx, 0);
            flush("table_pulses");
        end

        // Baud change inside a bit takes effect only from the next bit.
        baud_sel = 3'd0;
        idle(2);
        start_run();
        expect_bits(0,    5207, 2603, 324, 1, 0, 5207);
        expect_bits(5208, 2603, 1301, 161, 1, 1, 5208 + 2603);
        wait_stamp(t0 + 1 + 1000);
        chk("chg_bit_idx0", bit_idx, 0);
        baud_sel = 3'd1;
        wait_stamp(t0 + 1 + 5207);
        chk("chg_bit_idx1", bit_idx, 1);
        wait_stamp(t0 + 1 + 5208 + 2603);
        bps_start = 1'b0;
        @(negedge clk);
        flush("chg_pulses");

        // Full frame with auto-stop, then restart after bps_start toggles low.
        baud_sel   = 3'd5;
        div_custom = 16'd10;
        idle(2);
        start_run();
        expect_bits(0, 31, 15, 1, FRAME, 0, FRAME * 32 - 1);
        for (int b = 0; b < FRAME; b++) begin
            wait_stamp(t0 + 1 + b * 32 + 15);
            chk("frame_bit_idx", bit_idx, b);
        end
        wait_stamp(t0 + 1 + FRAME * 32 - 1);
        chk("frame_done_level", frame_done, 1);
        chk("frame_busy_last", busy, 1);
        chk("frame_bit_idx_wrap", bit_idx, 0);
        @(negedge clk);
        chk("frame_busy_halt", busy, 0);
        repeat (100) @(negedge clk);
        chk("halt_busy_held", busy, 0);
        chk("halt_bit_idx", bit_idx, 0);
        flush("frame_pulses");
        idle(1);
        start_run();
        expect_bits(0, 31, 15, 1, 1, 0, 31);
        wait_stamp(t0 + 1 + 31);
        chk("restart_bit_idx", bit_idx, 1);
        chk("restart_busy", busy, 1);
        bps_start = 1'b0;
        @(negedge clk);
        flush("restart_pulses");

        // bps_start dropped mid-bit.
        baud_sel = 3'd0;
        idle(2);
        start_run();
        expect_bits(0, 5207, 2603, 324, 1, 0, 3000);
        wait_stamp(t0 + 1 + 3000);
        bps_start = 1'b0;
        @(negedge clk);
        chk("drop_busy", busy, 0);
        chk("drop_bit_idx", bit_idx, 0);
        repeat (2300) @(negedge clk);
        flush("drop_pulses");

        // Asynchronous reset in the middle of a frame.
        baud_sel   = 3'd5;
        div_custom = 16'd10;
        idle(2);
        start_run();
        expect_bits(0, 31, 15, 1, FRAME, 0, 116);
        wait_stamp(t0 + 1 + 116);
        chk("pre_rst_bit_idx", bit_idx, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_clk_bps", clk_bps, 0);
        chk("rst_bit_end", bit_end, 0);
        chk("rst_os_tick", os_tick, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bit_idx", bit_idx, 0);
        bps_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        flush("rst_pulses");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised baud-rate timing generator for the UART RX/TX paths. It generalises the fixed 9600-baud mid-bit sampler in four ways: runtime baud selection, a custom divisor, a 16x oversample tick, and frame bit counting with an optional auto-stop. It sits between the UART control registers and the uart_rx/uart_tx shifters, and supplies all of their bit timing.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz; used to derive the preset divisors.
CNT_W, 16, width of the divisor and bit counters.
FRAME_BITS, 10, bit periods per frame (start + 8 data + stop).
AUTO_STOP, 1, 1 = halt after frame_done until bps_start is seen low.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset; asynchronous, active-low.
bps_start  input  1  run enable; level-sensitive.
baud_sel  input  3  0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=custom, 6/7=reserved (treated as 9600).
div_custom  input  CNT_W  custom divisor (bit period minus 1), used when baud_sel=5.
clk_bps  output  1  one-cycle pulse at mid-bit (sample point).
bit_end  output  1  one-cycle pulse at end of each bit period.
os_tick  output  1  one-cycle pulse at 16x the bit rate.
bit_idx  output  4  index of the current bit within the frame, 0..FRAME_BITS-1.
frame_done  output  1  one-cycle pulse when the last bit of a frame ends.
busy  output  1  high while running.

Behaviour:
- Reset: all outputs 0; cnt, os_cnt and bit_idx are 0; running=0; halted=0; div_q holds the 9600 divisor.
- Preset divisors: DIV = round(CLK_FREQ/baud) - 1. At 50 MHz these are 5207, 2603, 1301, 867 and 433.
- HALF = DIV>>1. At 50 MHz: 2603, 1301, 650, 433, 216.
- Custom divisor: div_custom values below 31 are clamped to 31.
- OS_DIV = ((DIV+1)>>4) - 1. For 9600 at 50 MHz this is 324.
- running = bps_start & !halted.
  - halted is set on frame_done when AUTO_STOP=1.
  - halted is cleared in any cycle where bps_start=0.
- Divisor latch: div_q and its derived HALF and OS_DIV load from baud_sel/div_custom when running=0, and at each bit wrap. A baud_sel change mid-bit never shortens or stretches the current bit.
- When running=0: cnt, os_cnt and bit_idx are forced to 0, and no pulses are produced.
- Bit counter, when running:
  - cnt increments each cycle.
  - If cnt==div_q, cnt wraps to 0 (bit wrap). Bit period = DIV+1 cycles.
- All pulse outputs are registered, one cycle after their condition:
  - clk_bps: condition cnt==HALF.
  - bit_end: condition cnt==div_q.
  - os_tick: condition os_cnt==OS_DIV.
- os_cnt:
  - increments while running;
  - wraps to 0 at OS_DIV;
  - is also forced to 0 on a bit wrap, so os ticks re-align every bit.
- Frame counting:
  - bit_idx increments on each bit wrap.
  - At a bit wrap with bit_idx==FRAME_BITS-1, bit_idx goes to 0 and frame_done pulses (registered, in the same cycle as bit_end).
- Timing reference: bps_start is first sampled high at edge 0.
  - First clk_bps is high after edge HALF.
  - First bit_end is high after edge DIV.
- bps_start dropping mid-bit: counters clear on the next edge and no further pulses are issued. Pulses already registered still complete their single cycle.
- Reset asserted mid-operation: immediate return to reset state.
- busy = registered running.

Decomposition:
- Package uart_pkg:
  - baud_sel encodings (BAUD_9600..BAUD_CUSTOM);
  - function baud_div(clk_freq, baud);
  - constant MIN_DIV=31;
  - constant OS_FACTOR=16.
- Sub-module uart_tick_counter: a generic wrap counter with inputs en, clr, limit and outputs cnt, wrap. Instantiated twice, for cnt and for os_cnt.

Test Plan:
- Reset, then bps_start=1, baud_sel=0 at 50 MHz -> clk_bps after edge 2603, then every 5208 cycles; bit_end after edge 5207, then every 5208.
- baud_sel=4 run -> clk_bps period 434 cycles with mid offset 216; 16 os_tick pulses per bit, spaced 27 cycles (OS_DIV=26), with the last gap truncated by re-align.
- Change baud_sel from 0 to 1 at cnt=1000 -> current bit still ends at cnt 5207; the next bit period is 2604.
- Full frame, FRAME_BITS=10, AUTO_STOP=1 -> bit_idx runs 0..9; frame_done coincides with the 10th bit_end; busy drops; no pulses while bps_start stays high; restart only after bps_start goes 0 then 1.
- baud_sel=5, div_custom=10 -> clamped to 31: bit period 32, clk_bps offset 15, os_tick every 2 cycles.
- Drop bps_start at cnt=3000, and separately assert rst_n=0 mid-frame -> all outputs 0 and counters 0 on the next edge (immediately for reset); baud_sel=7 behaves as 9600.
